sid_mix_engine: RTL and testbench
=================================

# sid_mix_engine

Parametrised, time-multiplexed voice mixer for multi-voice SID configurations (up to 8 voices). It replaces fixed three-voice parallel pre-filter and bypass adders with a single sequential accumulator that walks the voices once per sample frame. It hands the filter-routed sum to the external filter and waits for the filter's valid strobe. It then applies filter-mode selection, clipping and master volume, and owns the routing, mode, volume, mute and overrun registers in the SID address space.

## Interface
- VOICES, 3: number of voices, 1..8.
- SHIFT, 3: arithmetic right shift applied to each voice for headroom.
- BASE_ADDR, 'h17: register base; registers occupy BASE_ADDR+0..+3.
- clk  in  1  master clock.
- iRstN  in  1  reset; one clock; reset is asynchronous and active-low.
- iStart  in  1  frame strobe (1 MHz clkEn); sampled only in IDLE.
- iVoice  in  VOICES*16  signed voice amplitudes; voice i at [16i+15:16i].
- iWE  in  1  register write enable.
- iAddr  in  5  register address.
- iData  in  8  write data.
- oDataR  out  8  combinational read data.
- oPreFilter  out  16  signed saturated filter-routed sum.
- oPreValid  out  1  one-cycle pulse; oPreFilter is new.
- iFiltLP / iFiltBP / iFiltHP  in  16 each  signed filter outputs.
- iFiltValid  in  1  filter outputs valid for the current frame.
- oOut  out  16  signed final sample.
- oValid  out  1  one-cycle pulse; oOut is new.

## Operation
- Registers at BASE_ADDR offsets:
  - +0 route[7:0]: 1 sends the voice to the filter.
  - +1 {off, mode[2:0], vol[3:0]}: mode bit0 LP, bit1 BP, bit2 HP.
  - +2 mute[7:0].
  - +3 {7'b0, overrun}: any write clears overrun.
- Register bits at or above VOICES are written and read back but have no effect. Reads from any other address return 8'h00.
- Reset values: vol 4'hF; everything else 0; state IDLE; all outputs 0.
- States: IDLE, ACC, PRE, WAITF, MIX, VOL.
- IDLE, iStart sampled high:
  - Latch iVoice plus route, mute, off, mode and vol as a frame snapshot.
  - Clear both accumulators; idx=0; go to ACC.
- Register writes after the snapshot take effect next frame.
- ACC: each cycle processes voice idx.
  - Term = voice >>> SHIFT (sign-preserving), added to the accumulator selected below.
  - mute[idx]: term added to neither accumulator.
  - Else route[idx]: term added to the pre accumulator.
  - Else bypass accumulator, unless off && idx==VOICES-1.
  - After idx==VOICES-1, go to PRE.
- Accumulators are 20 bits signed and never overflow internally.
- PRE: oPreFilter <= sat16(pre); oPreValid=1 for this one cycle; go to WAITF.
- WAITF: hold until iFiltValid is sampled high, then go to MIX.
  - MIX: sum = sat16(bypass) + selected filter outputs (unselected contribute 0), 19-bit signed.
  - MIX: register clip16(sum); go to VOL.
- VOL: oOut <= (clip × vol) >>> 4, 16-bit signed × 4-bit unsigned, result cannot overflow; oValid=1; go to IDLE.
- sat16/clip16 clamp to 32767 / −32768.
- iStart high while not in IDLE: ignored, sets overrun (sticky).
- Simultaneous overrun set and a +3 write: set wins.
- iRstN low in any state: immediate return to reset values, no oValid; pending frame discarded.
- oPreFilter and oOut hold their last values between pulses.

## Timing
- iStart sampled at edge E0.
- ACC occupies E1..E(VOICES).
- oPreFilter/oPreValid are registered at E(VOICES+1).
- The earliest iFiltValid sample is E(VOICES+2), which registers MIX.
- oOut/oValid are registered at E(VOICES+3).
- VOICES=3 with iFiltValid tied to oPreValid: oValid is high for the cycle after E6.
- Maximum frame rate: one frame per VOICES+4 cycles; iStart every clk at a 1 MHz clkEn is always met for VOICES≤8 when clk ≥ 12 MHz.
- oDataR is purely combinational on iAddr and the registers.

## Test plan
- Reset with VOICES=3, SHIFT=3 -> read +1 returns 8'h0F; oOut=0, oValid=0, oPreFilter=0.
- Bypass path: voices {8000, 16000, −8000}, route 0, vol 15, iFiltValid tied to oPreValid -> oPreFilter=0, oOut=1875 (bypass 2000), oValid exactly at E6.
- Filter path: route 8'h01, mode LP, iFiltLP=500, same voices -> oPreFilter=1000, oOut=1406; with mode 0 -> oOut=937.
- Off and mute: off=1 -> voice2 dropped, oOut=2812; mute 8'h02 -> voice1 dropped from both paths.
- Saturation: VOICES=8, SHIFT=0, all voices 32767, vol 15 -> oOut=30719; all −32768, vol 15 -> oOut=−30720.
- Handshake and overrun: hold iFiltValid low for 10 cycles, pulse iStart in WAITF -> no restart, overrun reads 1, oValid 2 cycles after iFiltValid. Write +3 -> reads 0. Drop iRstN mid-ACC -> no oValid, outputs 0.

Source files
------------

// File: rtl/sid_mix_engine_if.sv
// Bus bundle for sid_mix_engine: frame strobe, voice inputs, register port,
// pre-filter handoff, filter return path and final sample output.
interface sid_mix_engine_if #(
    parameter int VOICES = 3
);
    logic                      iStart;
    logic [VOICES*16-1:0]      iVoice;
    logic                      iWE;
    logic [4:0]                iAddr;
    logic [7:0]                iData;
    logic [7:0]                oDataR;
    logic signed [15:0]        oPreFilter;
    logic                      oPreValid;
    logic signed [15:0]        iFiltLP;
    logic signed [15:0]        iFiltBP;
    logic signed [15:0]        iFiltHP;
    logic                      iFiltValid;
    logic signed [15:0]        oOut;
    logic                      oValid;

    modport master (
        output iStart, iVoice, iWE, iAddr, iData,
        output iFiltLP, iFiltBP, iFiltHP, iFiltValid,
        input  oDataR, oPreFilter, oPreValid, oOut, oValid
    );

    modport slave (
        input  iStart, iVoice, iWE, iAddr, iData,
        input  iFiltLP, iFiltBP, iFiltHP, iFiltValid,
        output oDataR, oPreFilter, oPreValid, oOut, oValid
    );
endinterface

// File: rtl/sid_mix_engine.sv
// Time-multiplexed SID voice mixer: one shared accumulator pass per frame,
// hand-off to an external filter, then mode select, clip and master volume.
//
// state | meaning
// IDLE  | waiting for iStart; snapshot voices and registers on start
// ACC   | one voice per cycle into the pre-filter or bypass accumulator
// PRE   | publish saturated pre-filter sum, pulse oPreValid
// WAITF | wait for iFiltValid; on that edge the mix (bypass + selected
//       | filter outputs, clipped) is registered, so a frame fits in
//       | VOICES+4 cycles
// VOL   | apply master volume to the clipped mix, pulse oValid
module sid_mix_engine #(
    parameter int         VOICES    = 3,
    parameter int         SHIFT     = 3,
    parameter logic [4:0] BASE_ADDR = 5'h17
) (
    input logic             clk,
    input logic             iRstN,
    sid_mix_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACC, PRE, WAITF, VOL} state_t;

    localparam logic [4:0] ADDR_ROUTE = BASE_ADDR;
    localparam logic [4:0] ADDR_CTRL  = BASE_ADDR + 5'd1;
    localparam logic [4:0] ADDR_MUTE  = BASE_ADDR + 5'd2;
    localparam logic [4:0] ADDR_OVR   = BASE_ADDR + 5'd3;
    localparam logic [2:0] LAST       = 3'(VOICES - 1);

    logic [7:0] route_q, ctrl_q, mute_q;
    logic       overrun_q;

    state_t                 state_q;
    logic [2:0]             idx_q;
    logic [VOICES*16-1:0]   voice_q;
    logic [7:0]             s_route_q, s_mute_q;
    logic                   s_off_q;
    logic [2:0]             s_mode_q;
    logic [3:0]             s_vol_q;
    logic signed [19:0]     pre_acc_q, byp_acc_q;
    logic signed [15:0]     clip_q, pre_out_q, out_q;
    logic                   pre_valid_q, valid_q;

    logic signed [15:0]     voice_cur;
    logic signed [19:0]     term;
    logic signed [19:0]     mix_sum;
    logic signed [20:0]     scaled;

    function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
        if (v > 20'sd32767)
            return 16'sh7FFF;
        else if (v < -20'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    assign voice_cur = voice_q[{idx_q, 4'b0000} +: 16];
    assign term      = $signed({{4{voice_cur[15]}}, voice_cur}) >>> SHIFT;
    assign mix_sum   = sat16(byp_acc_q)
                     + (s_mode_q[0] ? bus.iFiltLP : 16'sd0)
                     + (s_mode_q[1] ? bus.iFiltBP : 16'sd0)
                     + (s_mode_q[2] ? bus.iFiltHP : 16'sd0);
    assign scaled    = clip_q * $signed({1'b0, s_vol_q});

    // Register file writes; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            route_q   <= 8'h00;
            ctrl_q    <= 8'h0F;
            mute_q    <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            if (bus.iWE && bus.iAddr == ADDR_ROUTE) route_q <= bus.iData;
            if (bus.iWE && bus.iAddr == ADDR_CTRL)  ctrl_q  <= bus.iData;
            if (bus.iWE && bus.iAddr == ADDR_MUTE)  mute_q  <= bus.iData;
            if (bus.iStart && state_q != IDLE)
                overrun_q <= 1'b1;
            else if (bus.iWE && bus.iAddr == ADDR_OVR)
                overrun_q <= 1'b0;
        end
    end

    // Combinational read-back; unmapped addresses read as zero.
    always_comb begin
        bus.oDataR = 8'h00;
        case (bus.iAddr)
            ADDR_ROUTE: bus.oDataR = route_q;
            ADDR_CTRL:  bus.oDataR = ctrl_q;
            ADDR_MUTE:  bus.oDataR = mute_q;
            ADDR_OVR:   bus.oDataR = {7'b0, overrun_q};
            default:    bus.oDataR = 8'h00;
        endcase
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            voice_q     <= '0;
            s_route_q   <= 8'h00;
            s_mute_q    <= 8'h00;
            s_off_q     <= 1'b0;
            s_mode_q    <= 3'd0;
            s_vol_q     <= 4'hF;
            pre_acc_q   <= '0;
            byp_acc_q   <= '0;
            clip_q      <= '0;
            pre_out_q   <= '0;
            out_q       <= '0;
            pre_valid_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            pre_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.iStart) begin
                        voice_q   <= bus.iVoice;
                        s_route_q <= route_q;
                        s_mute_q  <= mute_q;
                        s_off_q   <= ctrl_q[7];
                        s_mode_q  <= ctrl_q[6:4];
                        s_vol_q   <= ctrl_q[3:0];
                        pre_acc_q <= '0;
                        byp_acc_q <= '0;
                        idx_q     <= 3'd0;
                        state_q   <= ACC;
                    end
                end
                ACC: begin
                    if (!s_mute_q[idx_q]) begin
                        if (s_route_q[idx_q])
                            pre_acc_q <= pre_acc_q + term;
                        else if (!(s_off_q && idx_q == LAST))
                            byp_acc_q <= byp_acc_q + term;
                    end
                    if (idx_q == LAST)
                        state_q <= PRE;
                    else
                        idx_q <= idx_q + 3'd1;
                end
                PRE: begin
                    pre_out_q   <= sat16(pre_acc_q);
                    pre_valid_q <= 1'b1;
                    state_q     <= WAITF;
                end
                WAITF: begin
                    if (bus.iFiltValid) begin
                        clip_q  <= sat16(mix_sum);
                        state_q <= VOL;
                    end
                end
                VOL: begin
                    out_q   <= 16'(scaled >>> 4);
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oPreFilter = pre_out_q;
    assign bus.oPreValid  = pre_valid_q;
    assign bus.oOut       = out_q;
    assign bus.oValid     = valid_q;
endmodule

// File: tb/tb_sid_mix_engine.sv
module tb_sid_mix_engine;
    localparam logic [4:0] A0 = 5'h17;
    localparam logic [4:0] A1 = 5'h18;
    localparam logic [4:0] A2 = 5'h19;
    localparam logic [4:0] A3 = 5'h1A;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic sel8;
    logic tie;
    logic [15:0] vin [8];
    logic signed [15:0] f_lp, f_bp, f_hp;
    logic f_valid;
    logic [7:0] m_route, m_ctrl, m_mute;

    always #5 clk = ~clk;

    sid_mix_engine_if #(.VOICES(3)) b3 ();
    sid_mix_engine_if #(.VOICES(8)) b8 ();

    assign b3.iVoice = {vin[2], vin[1], vin[0]};
    assign b8.iVoice = {vin[7], vin[6], vin[5], vin[4], vin[3], vin[2], vin[1], vin[0]};
    assign b3.iFiltLP = f_lp;
    assign b3.iFiltBP = f_bp;
    assign b3.iFiltHP = f_hp;
    assign b8.iFiltLP = f_lp;
    assign b8.iFiltBP = f_bp;
    assign b8.iFiltHP = f_hp;
    assign b3.iFiltValid = ~sel8 & (f_valid | (tie & b3.oPreValid));
    assign b8.iFiltValid =  sel8 & (f_valid | (tie & b8.oPreValid));

    sid_mix_engine #(.VOICES(3), .SHIFT(3), .BASE_ADDR(5'h17)) dut3 (
        .clk(clk), .iRstN(rst_n), .bus(b3));
    sid_mix_engine #(.VOICES(8), .SHIFT(0), .BASE_ADDR(5'h17)) dut8 (
        .clk(clk), .iRstN(rst_n), .bus(b8));

    logic signed [15:0] o_out, o_pre;
    logic o_valid, o_prev;
    logic [7:0] o_rd;

    always_comb begin
        if (sel8) begin
            o_out = b8.oOut; o_pre = b8.oPreFilter;
            o_valid = b8.oValid; o_prev = b8.oPreValid; o_rd = b8.oDataR;
        end else begin
            o_out = b3.oOut; o_pre = b3.oPreFilter;
            o_valid = b3.oValid; o_prev = b3.oPreValid; o_rd = b3.oDataR;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_bus(input logic st, input logic we, input logic [4:0] a, input logic [7:0] d);
        b3.iStart = st & ~sel8;  b8.iStart = st & sel8;
        b3.iWE    = we & ~sel8;  b8.iWE    = we & sel8;
        b3.iAddr  = a;           b8.iAddr  = a;
        b3.iData  = d;           b8.iData  = d;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk); drive_bus(1'b0, 1'b1, a, d);
        @(negedge clk); drive_bus(1'b0, 1'b0, a, 8'h00);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] v);
        @(negedge clk); drive_bus(1'b0, 1'b0, a, 8'h00);
        #1 v = o_rd;
    endtask

    task automatic set_regs(input logic [7:0] r, input logic [7:0] c, input logic [7:0] m);
        m_route = r; m_ctrl = c; m_mute = m;
        wr(A0, r); wr(A1, c); wr(A2, m);
    endtask

    function automatic int sat(input int v);
        return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
    endfunction

    // Frame result from the register rules, using plain integer arithmetic.
    function automatic void model(input int nv, input int sh, output int pre_e, output int out_e);
        int pre_s, byp_s, t, s, c;
        pre_s = 0; byp_s = 0;
        for (int i = 0; i < nv; i++) begin
            t = int'($signed(vin[i])) >>> sh;
            if (m_mute[i]) continue;
            if (m_route[i]) pre_s += t;
            else if (!(m_ctrl[7] && i == nv - 1)) byp_s += t;
        end
        pre_e = sat(pre_s);
        s = sat(byp_s) + (m_ctrl[4] ? int'(f_lp) : 0)
                       + (m_ctrl[5] ? int'(f_bp) : 0)
                       + (m_ctrl[6] ? int'(f_hp) : 0);
        c = sat(s);
        out_e = (c * int'(m_ctrl[3:0])) >>> 4;
    endfunction

    task automatic frame(input string tag, input int fdelay, input bit ovr_poke,
                         input bit late_vol, output int obs_pre, output int obs_out);
        int nv, sh, pre_e, out_e, cyc, fv;
        bit seen;
        nv = sel8 ? 8 : 3;
        sh = sel8 ? 0 : 3;
        model(nv, sh, pre_e, out_e);
        @(negedge clk); drive_bus(1'b1, 1'b0, 5'h00, 8'h00);
        @(negedge clk);
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            if (o_prev) seen = 1;
            else begin
                drive_bus(1'b0, late_vol && cyc == 0, A1, {m_ctrl[7:4], 4'h0});
                @(negedge clk); cyc++;
            end
        end
        drive_bus(1'b0, 1'b0, 5'h00, 8'h00);
        chk({tag, "_pre_time"}, cyc, nv + 1);
        chk({tag, "_pre"}, o_pre, pre_e);
        obs_pre = int'(o_pre);
        for (int d = 0; d < fdelay; d++) begin
            @(negedge clk); cyc++;
            drive_bus(ovr_poke && d == 3, 1'b0, 5'h00, 8'h00);
        end
        drive_bus(1'b0, 1'b0, 5'h00, 8'h00);
        f_valid = 1'b1; fv = cyc;
        @(negedge clk); cyc++;
        f_valid = 1'b0;
        while (!o_valid && cyc < fv + 40) begin
            @(negedge clk); cyc++;
        end
        chk({tag, "_out_time"}, cyc, fv + 2);
        chk({tag, "_out"}, o_out, out_e);
        obs_out = int'(o_out);
        @(negedge clk);
        chk({tag, "_pulse"}, o_valid, 1'b0);
        chk({tag, "_hold"}, o_out, out_e);
        if (late_vol) m_ctrl = {m_ctrl[7:4], 4'h0};
    endtask

    initial begin
        logic [7:0] rv;
        int p, o, any;
        sel8 = 1'b0; tie = 1'b0; f_valid = 1'b0;
        f_lp = '0; f_bp = '0; f_hp = '0;
        for (int i = 0; i < 8; i++) vin[i] = '0;
        m_route = 8'h00; m_ctrl = 8'h0F; m_mute = 8'h00;
        drive_bus(1'b0, 1'b0, 5'h00, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", o_out, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_pre", o_pre, 0);
        chk("rst_prev", o_prev, 0);
        rd(A1, rv); chk("rst_ctrl", rv, 8'h0F);
        rd(A0, rv); chk("rst_route", rv, 8'h00);
        rd(A3, rv); chk("rst_ovr", rv, 8'h00);
        @(negedge clk); rst_n = 1'b1;

        // directed paths with the three-voice instance
        vin[0] = 16'd8000; vin[1] = 16'd16000; vin[2] = -16'sd8000;
        set_regs(8'h00, 8'h0F, 8'h00);
        frame("bypass", 0, 0, 0, p, o);
        chk("bypass_k_pre", p, 0); chk("bypass_k_out", o, 1875);
        f_lp = 16'sd500;
        set_regs(8'h01, 8'h1F, 8'h00);
        frame("lp", 0, 0, 0, p, o);
        chk("lp_k_pre", p, 1000); chk("lp_k_out", o, 1406);
        set_regs(8'h01, 8'h0F, 8'h00);
        frame("nomode", 1, 0, 0, p, o);
        chk("nomode_k_out", o, 937);
        set_regs(8'h00, 8'h8F, 8'h00);
        frame("off", 2, 0, 0, p, o);
        chk("off_k_out", o, 2812);
        set_regs(8'h01, 8'h1F, 8'h02);
        frame("mute", 0, 0, 0, p, o);
        chk("mute_k_out", o, -469);

        // decode and read-back
        wr(A0, 8'hFF); rd(A0, rv); chk("route_hi_bits", rv, 8'hFF);
        wr(5'h1B, 8'h5A); rd(5'h1B, rv); chk("unmapped_hi", rv, 8'h00);
        rd(5'h16, rv); chk("unmapped_lo", rv, 8'h00);

        // register write during a frame applies to the next one
        set_regs(8'h00, 8'h0F, 8'h00);
        frame("latevol", 0, 0, 1, p, o);
        chk("latevol_k_out", o, 1875);
        frame("nextvol", 0, 0, 0, p, o);
        chk("nextvol_k_out", o, 0);

        // overrun and filter handshake stall
        set_regs(8'h00, 8'h0F, 8'h00);
        frame("stall", 10, 1, 0, p, o);
        any = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); if (o_prev) any = 1;
        end
        chk("no_restart", any, 0);
        rd(A3, rv); chk("ovr_set", rv, 8'h01);
        wr(A3, 8'h00); rd(A3, rv); chk("ovr_clr", rv, 8'h00);
        tie = 1'b1;
        @(negedge clk); drive_bus(1'b1, 1'b0, 5'h00, 8'h00);
        @(negedge clk); drive_bus(1'b1, 1'b1, A3, 8'h00);
        @(negedge clk); drive_bus(1'b0, 1'b0, 5'h00, 8'h00);
        repeat (12) @(negedge clk);
        rd(A3, rv); chk("ovr_set_wins", rv, 8'h01);
        wr(A3, 8'h00);
        tie = 1'b0;

        // randomized frames, three voices
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 8; i++) vin[i] = 16'($urandom);
            f_lp = 16'($urandom); f_bp = 16'($urandom); f_hp = 16'($urandom);
            set_regs(8'($urandom), 8'($urandom), 8'($urandom));
            frame("rnd3", int'($urandom_range(0, 4)), 0, 0, p, o);
        end

        // eight voices, no headroom shift
        sel8 = 1'b1;
        for (int i = 0; i < 8; i++) vin[i] = 16'h7FFF;
        set_regs(8'h00, 8'h0F, 8'h00);
        frame("satpos", 0, 0, 0, p, o);
        chk("satpos_k_out", o, 30719);
        set_regs(8'hFF, 8'h0F, 8'h00);
        frame("satpre", 0, 0, 0, p, o);
        chk("satpre_k_pre", p, 32767);
        for (int i = 0; i < 8; i++) vin[i] = 16'h8000;
        set_regs(8'h00, 8'h0F, 8'h00);
        frame("satneg", 0, 0, 0, p, o);
        chk("satneg_k_out", o, -30720);
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 8; i++) vin[i] = 16'($urandom);
            f_lp = 16'($urandom); f_bp = 16'($urandom); f_hp = 16'($urandom);
            set_regs(8'($urandom), 8'($urandom), 8'($urandom));
            frame("rnd8", int'($urandom_range(0, 4)), 0, 0, p, o);
        end

        // reset in the middle of accumulation
        sel8 = 1'b0; tie = 1'b1;
        vin[0] = 16'd8000; vin[1] = 16'd16000; vin[2] = -16'sd8000;
        set_regs(8'h01, 8'h1F, 8'h00);
        @(negedge clk); drive_bus(1'b1, 1'b0, 5'h00, 8'h00);
        @(negedge clk); drive_bus(1'b0, 1'b0, 5'h00, 8'h00);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("mid_rst_out", o_out, 0);
        chk("mid_rst_pre", o_pre, 0);
        chk("mid_rst_valid", o_valid, 0);
        rd(A1, rv); chk("mid_rst_ctrl", rv, 8'h0F);
        @(negedge clk); rst_n = 1'b1;
        any = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); if (o_valid || o_prev) any = 1;
        end
        chk("mid_rst_no_valid", any, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
